ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite slave with a single-port word-organised SRAM. It is the responder end of the bus that the CPU
//  fetch/exec master drives, and it holds instructions and data.
//  Responds with OKAY or two-cycle ERROR, with programmable wait states. Supports byte, halfword and word accesses.
// PARAMETERS
//  WIDTH        32  data/address bus width (only 32 supported)
//  DEPTH        1024 number of 32-bit words; valid byte range 0 .. DEPTH*4-1
//  WAIT_STATES  0   hready_o low cycles inserted per OKAY data phase (0..15)
// PORTS
//  hclk_i     in   1      bus clock, all state on rising edge
//  hreset_i   in   1      asynchronous, active-high reset
//  hsel_i     in   1      slave select from decoder
//  htrans_i   in   2      IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  haddr_i    in   WIDTH  byte address
//  hwrite_i   in   1      1=write 0=read
//  hsize_i    in   3      000 byte, 001 halfword, 010 word, others illegal
//  hburst_i   in   3      ignored (each beat handled independently)
//  hwdata_i   in   WIDTH  write data, valid in data phase
//  hready_i   in   1      bus-wide HREADY (previous transfer complete)
//  hready_o   out  1      this slave's data phase complete
//  hresp_o    out  2      OKAY=00 ERROR=01
//  hrdata_o   out  WIDTH  read data, valid when hready_o=1 and hresp_o=OKAY
// BEHAVIOUR
//  Reset: hready_o=1, hresp_o=OKAY, hrdata_o=0, FSM=IDLE, no pending transfer. SRAM contents are not reset.
//  Accept: an address phase is taken when hsel_i & htrans_i[1] & hready_i.
//   On accept, haddr/hwrite/hsize are latched. IDLE/BUSY/unselected phases get zero-wait OKAY.
//  Error check at accept:
//   - addr >= DEPTH*4
//   - hsize_i > 010
//   - halfword with haddr_i[0]=1
//   - word with haddr_i[1:0]!=0
//  FSM states IDLE, WAIT, ERR1, ERR2:
//   IDLE: accept+error -> ERR1.
//         accept+ok with WAIT_STATES>0 -> WAIT, loading the counter with WAIT_STATES-1.
//         accept+ok with WAIT_STATES=0 -> stays IDLE, and the data phase completes next cycle.
//   WAIT: hready_o=0, hresp_o=OKAY. The counter decrements each cycle.
//         At 0, the next cycle has hready_o=1 and the transfer completes; go IDLE, or go direct to the next
//         state if a new accept coincides.
//   ERR1: hready_o=0, hresp_o=ERROR -> ERR2.
//   ERR2: hready_o=1, hresp_o=ERROR. An address phase presented here is accepted (hready_i=1),
//         and the next state follows IDLE rules.
//  Write: the SRAM is updated on the clock edge ending the OKAY data phase (hready_o=1).
//   Byte lanes come from the latched haddr[1:0] and hsize (little-endian); other lanes are unchanged.
//   An ERROR write never modifies SRAM.
//  Read: hrdata_o is registered from SRAM[addr[..:2]] as the full 32-bit word, so the master selects lanes.
//   It is valid in the cycle hready_o=1. After ERROR or non-read phases, hrdata_o holds its last value.
//  Read-after-write hazard: a read accepted in the same cycle that a write completes to the same word
//   returns the merged new data (forwarding), never the stale word.
//  Back-to-back: with WAIT_STATES=0, pipelined NONSEQ/SEQ beats complete one per cycle with no bubbles.
//  Address and data phases overlap per AHB-Lite.
//  Reset asserted mid-transfer: transfer abandoned, pending write not performed, outputs take reset values.
//  hsel_i low while the slave is in WAIT/ERR: the in-flight data phase still completes normally.
// TESTING
//  1. Reset: hreset_i=1 for 3 cycles, then release -> hready_o=1, hresp_o=00, hrdata_o=0.
//  2. WAIT_STATES=0: word write 0xDEADBEEF to 0x10, next cycle word read 0x10 (back-to-back) ->
//     hrdata_o=0xDEADBEEF, no hready_o low cycles.
//  3. Byte write 0xAA to 0x11 over 0x00000000, then word read 0x10 -> 0x0000AA00.
//     Halfword write 0x1234 to 0x12, then read -> 0x1234AA00.
//  4. WAIT_STATES=2: word read -> exactly 2 cycles hready_o=0, then hready_o=1 with data, hresp_o=00.
//  5. Word write to 0x02 (misaligned) and read of DEPTH*4 ->
//     hresp_o=01 for 2 cycles (hready_o 0 then 1), SRAM at word 0 unchanged.
//  6. Assert hreset_i during WAIT of a write to 0x20 -> outputs reset, and a later read of 0x20 returns
//     the prior contents.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master/interconnect and the SRAM slave.
// hready is the bus-wide ready seen by everyone; hreadyout is this slave's own contribution.
interface ahb_sram_slave_if #(
   parameter int WIDTH = 32
);
   logic             hsel;
   logic [1:0]       htrans;
   logic [WIDTH-1:0] haddr;
   logic             hwrite;
   logic [2:0]       hsize;
   logic [2:0]       hburst;
   logic [WIDTH-1:0] hwdata;
   logic             hready;
   logic             hreadyout;
   logic [1:0]       hresp;
   logic [WIDTH-1:0] hrdata;

   modport master (
      output hsel, htrans, haddr, hwrite, hsize, hburst, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, htrans, haddr, hwrite, hsize, hburst, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised single-port SRAM, with programmable
// OKAY wait states, two-cycle ERROR responses and byte/halfword/word lanes.
//
// state   | meaning
// ST_IDLE | no stall; finishes any pending OKAY data phase, takes new address phases
// ST_WAIT | OKAY data phase stalled, wait_cnt counts down to terminal count 0
// ST_ERR1 | first ERROR cycle, hreadyout low
// ST_ERR2 | second ERROR cycle, hreadyout high, may take the next address phase
module ahb_sram_slave #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input logic             hclk,
   input logic             hreset,
   ahb_sram_slave_if.slave bus
);
   localparam int               AW         = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] BYTE_LIMIT = WIDTH'(DEPTH * 4);
   localparam logic [1:0]       RESP_OKAY  = 2'b00;
   localparam logic [1:0]       RESP_ERROR = 2'b01;
   localparam logic [2:0]       SIZE_BYTE  = 3'b000;
   localparam logic [2:0]       SIZE_HALF  = 3'b001;
   localparam logic [2:0]       SIZE_WORD  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   state_t         state;
   logic [3:0]     wait_cnt;
   logic           pend;
   logic           lat_write;
   logic [AW-1:0]  lat_word;
   logic [3:0]     lat_mask;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             can_accept;
   logic             accept;
   logic             addr_err;
   logic             wr_en;
   logic             rd_en;
   logic [AW-1:0]    addr_word;
   logic [WIDTH-1:0] rd_word;
   logic             unused_bus;

   function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
      case (sz)
         SIZE_BYTE: lane_mask = 4'b0001 << a;
         SIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
         default:   lane_mask = 4'b1111;
      endcase
   endfunction

   assign unused_bus = ^{bus.hburst, bus.htrans[0]};

   // only the non-stalled states can own an address phase, even if hready is stray high
   assign can_accept = (state == ST_IDLE) || (state == ST_ERR2);
   assign accept     = bus.hsel & bus.htrans[1] & bus.hready & can_accept;
   assign addr_word  = bus.haddr[AW+1:2];
   assign rd_en      = accept & ~addr_err & ~bus.hwrite;
   assign wr_en      = (state == ST_IDLE) & pend & lat_write;

   always_comb begin
      addr_err = 1'b0;
      if (bus.haddr >= BYTE_LIMIT)
         addr_err = 1'b1;
      if (bus.hsize > SIZE_WORD)
         addr_err = 1'b1;
      if ((bus.hsize == SIZE_HALF) && bus.haddr[0])
         addr_err = 1'b1;
      if ((bus.hsize == SIZE_WORD) && (bus.haddr[1:0] != 2'b00))
         addr_err = 1'b1;
   end

   // a read landing on the word being written this edge sees the merged new data
   always_comb begin
      rd_word = mem[addr_word];
      if (wr_en && (lat_word == addr_word)) begin
         for (int b = 0; b < 4; b++) begin
            if (lat_mask[b])
               rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (lat_mask[b])
               mem[lat_word][8*b +: 8] <= bus.hwdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         pend          <= 1'b0;
         lat_write     <= 1'b0;
         lat_word      <= '0;
         lat_mask      <= '0;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= RESP_OKAY;
         bus.hrdata    <= '0;
      end else begin
         if (rd_en)
            bus.hrdata <= rd_word;
         case (state)
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state         <= ST_IDLE;
                  bus.hreadyout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state         <= ST_ERR2;
               bus.hreadyout <= 1'b1;
            end
            default: begin
               state         <= ST_IDLE;
               pend          <= 1'b0;
               bus.hreadyout <= 1'b1;
               bus.hresp     <= RESP_OKAY;
               if (accept) begin
                  lat_write <= bus.hwrite;
                  lat_word  <= addr_word;
                  lat_mask  <= lane_mask(bus.haddr[1:0], bus.hsize);
                  if (addr_err) begin
                     state         <= ST_ERR1;
                     bus.hreadyout <= 1'b0;
                     bus.hresp     <= RESP_ERROR;
                  end else begin
                     pend <= 1'b1;
                     if (WAIT_STATES != 0) begin
                        state         <= ST_WAIT;
                        wait_cnt      <= 4'(WAIT_STATES - 1);
                        bus.hreadyout <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait instance and one two-wait-state instance on a shared clock/reset.
module tb_ahb_sram_slave;
   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;
   localparam logic [2:0] SZ_B     = 3'b000;
   localparam logic [2:0] SZ_H     = 3'b001;
   localparam logic [2:0] SZ_W     = 3'b010;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   lows0  = 0;
   int   lows;
   logic [1:0] resp_low;

   ahb_sram_slave_if b0 ();
   ahb_sram_slave_if b2 ();

   assign b0.hready = b0.hreadyout;
   assign b2.hready = b2.hreadyout;

   ahb_sram_slave #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
      .hclk   (clk),
      .hreset (rst),
      .bus    (b0.slave)
   );

   ahb_sram_slave #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) dut2 (
      .hclk   (clk),
      .hreset (rst),
      .bus    (b2.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // one zero-wait cycle: address phase for this beat, write data for the previous beat
   task automatic cyc0(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] size, input logic [31:0] wdata);
      b0.hsel   = sel;
      b0.htrans = trans;
      b0.haddr  = addr;
      b0.hwrite = wr;
      b0.hsize  = size;
      b0.hwdata = wdata;
      @(posedge clk);
      #1;
      if (b0.hreadyout !== 1'b1)
         lows0++;
   endtask

   // single transfer on the wait-state instance; returns in the cycle hreadyout is high again
   task automatic xfer2(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output int n_low, output logic [1:0] r_low);
      b2.hsel   = 1'b1;
      b2.htrans = T_NONSEQ;
      b2.haddr  = addr;
      b2.hwrite = wr;
      b2.hsize  = size;
      @(posedge clk);
      #1;
      b2.hsel   = 1'b0;
      b2.htrans = T_IDLE;
      b2.hwdata = wdata;
      n_low = 0;
      r_low = 2'b11;
      while ((b2.hreadyout !== 1'b1) && (n_low < 20)) begin
         if (n_low == 0)
            r_low = b2.hresp;
         n_low++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      b0.hsel = 1'b0; b0.htrans = T_IDLE; b0.haddr = '0; b0.hwrite = 1'b0;
      b0.hsize = SZ_W; b0.hburst = 3'b000; b0.hwdata = '0;
      b2.hsel = 1'b0; b2.htrans = T_IDLE; b2.haddr = '0; b2.hwrite = 1'b0;
      b2.hsize = SZ_W; b2.hburst = 3'b000; b2.hwdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst0_hready", 32'(b0.hreadyout), 32'd1);
      check("rst0_hresp",  32'(b0.hresp),     32'd0);
      check("rst0_hrdata", b0.hrdata,         32'h0);
      check("rst2_hready", 32'(b2.hreadyout), 32'd1);
      check("rst2_hresp",  32'(b2.hresp),     32'd0);
      check("rst2_hrdata", b2.hrdata,         32'h0);

      // zero wait states: write then immediately read the same word
      cyc0(1'b1, T_NONSEQ, 32'h10, 1'b1, SZ_W, 32'h0);
      cyc0(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_W, 32'hDEADBEEF);
      check("b2b_rdata", b0.hrdata, 32'hDEADBEEF);
      check("b2b_hresp", 32'(b0.hresp), 32'd0);

      // byte and halfword lanes merged into a zeroed word
      cyc0(1'b1, T_NONSEQ, 32'h10, 1'b1, SZ_W, 32'h0);
      cyc0(1'b1, T_SEQ,    32'h11, 1'b1, SZ_B, 32'h0);
      cyc0(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_W, 32'h0000AA00);
      check("byte_rdata", b0.hrdata, 32'h0000AA00);
      cyc0(1'b1, T_NONSEQ, 32'h12, 1'b1, SZ_H, 32'h0);
      cyc0(1'b1, T_NONSEQ, 32'h10, 1'b0, SZ_W, 32'h12340000);
      check("half_rdata", b0.hrdata, 32'h1234AA00);
      cyc0(1'b1, T_SEQ,    32'h13, 1'b0, SZ_B, 32'h0);
      check("mem_rdata", b0.hrdata, 32'h1234AA00);
      cyc0(1'b0, T_IDLE,   32'h0,  1'b0, SZ_W, 32'h0);
      check("ws0_no_stall", 32'(lows0), 32'd0);

      // two wait states
      xfer2(32'h40, 1'b1, SZ_W, 32'hCAFEF00D, lows, resp_low);
      check("ws2_wr_lows", 32'(lows), 32'd2);
      check("ws2_wr_resp", 32'(resp_low), 32'd0);
      xfer2(32'h40, 1'b0, SZ_W, 32'h0, lows, resp_low);
      check("ws2_rd_lows",  32'(lows), 32'd2);
      check("ws2_rd_hresp", 32'(b2.hresp), 32'd0);
      check("ws2_rd_data",  b2.hrdata, 32'hCAFEF00D);

      // error responses; word 0 must keep its contents
      xfer2(32'h00, 1'b1, SZ_W, 32'h11223344, lows, resp_low);
      xfer2(32'h02, 1'b1, SZ_W, 32'hFFFFFFFF, lows, resp_low);
      check("mis_lows",     32'(lows), 32'd1);
      check("mis_resp_lo",  32'(resp_low), 32'd1);
      check("mis_resp_hi",  32'(b2.hresp), 32'd1);
      xfer2(32'd4096, 1'b0, SZ_W, 32'h0, lows, resp_low);
      check("oob_lows",     32'(lows), 32'd1);
      check("oob_resp_lo",  32'(resp_low), 32'd1);
      check("oob_resp_hi",  32'(b2.hresp), 32'd1);
      check("oob_rdata_hold", b2.hrdata, 32'hCAFEF00D);
      xfer2(32'h00, 1'b0, SZ_W, 32'h0, lows, resp_low);
      check("w0_lows",  32'(lows), 32'd2);
      check("w0_hresp", 32'(b2.hresp), 32'd0);
      check("w0_rdata", b2.hrdata, 32'h11223344);

      // reset in the middle of a stalled write
      xfer2(32'h20, 1'b1, SZ_W, 32'h5A5A5A5A, lows, resp_low);
      @(posedge clk);
      #1;
      b2.hsel = 1'b1; b2.htrans = T_NONSEQ; b2.haddr = 32'h20; b2.hwrite = 1'b1; b2.hsize = SZ_W;
      @(posedge clk);
      #1;
      b2.hsel = 1'b0; b2.htrans = T_IDLE; b2.hwdata = 32'h0BADF00D;
      check("midrst_stalled", 32'(b2.hreadyout), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("midrst_hready", 32'(b2.hreadyout), 32'd1);
      check("midrst_hresp",  32'(b2.hresp),     32'd0);
      check("midrst_hrdata", b2.hrdata,         32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      xfer2(32'h20, 1'b0, SZ_W, 32'h0, lows, resp_low);
      check("midrst_lows",  32'(lows), 32'd2);
      check("midrst_rdata", b2.hrdata, 32'h5A5A5A5A);
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
